// File: rtl/multi_wave_node_generator_if.sv
// Waveform node bus shared between the note-select logic and one generator channel.
//   select        node select (lowest set bit wins, 0 = idle)
//   mode          waveform mode (00 triangle, 01 sawtooth, 10 square, 11 triangle)
//   out           registered DATA_W-bit sample
//   step          one-cycle pulse on every phase step
//   period_start  one-cycle pulse when the phase returns to 0
// master drives select/mode; slave (the generator) drives the sample side.
interface multi_wave_node_generator_if #(
    parameter int unsigned DATA_W = 12
);
    logic [4:0]        select;
    logic [1:0]        mode;
    logic [DATA_W-1:0] out;
    logic              step;
    logic              period_start;

    modport master (output select, mode, input out, step, period_start);
    modport slave  (input select, mode, output out, step, period_start);
endinterface

// File: rtl/multi_wave_node_generator.sv
// Multi-mode tone source: triangle, sawtooth or square wave for one of five nodes.
// Note and mode changes made while running take effect only at the period boundary.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of multi_wave_node_generator_if (select, mode in;
//          out, step, period_start out)
module multi_wave_node_generator #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned DIV0   = 23,
    parameter int unsigned DIV1   = 21,
    parameter int unsigned DIV2   = 18,
    parameter int unsigned DIV3   = 17,
    parameter int unsigned DIV4   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    multi_wave_node_generator_if.slave     bus
);
    localparam logic [DATA_W-1:0] MAX    = '1;
    localparam logic [DATA_W-1:0] MAX_M1 = MAX - 1'b1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   div_cnt;
    logic [CNT_W-1:0]   cur_div;
    logic [CNT_W-1:0]   dec_div;
    logic [1:0]         cur_mode;
    logic [DATA_W-1:0]  phase, phase_nxt;
    logic [DATA_W-1:0]  out_q, sample_nxt;
    logic               dir_up, dir_nxt;
    logic               step_q, ps_q;
    logic               tick, wrap, is_tri;

    assign bus.out          = out_q;
    assign bus.step         = step_q;
    assign bus.period_start = ps_q;

    assign is_tri = (cur_mode != 2'b01) && (cur_mode != 2'b10);

    // Lowest set select bit wins.
    always_comb begin
        dec_div = CNT_W'(DIV0);
        if (bus.select[0])      dec_div = CNT_W'(DIV0);
        else if (bus.select[1]) dec_div = CNT_W'(DIV1);
        else if (bus.select[2]) dec_div = CNT_W'(DIV2);
        else if (bus.select[3]) dec_div = CNT_W'(DIV3);
        else if (bus.select[4]) dec_div = CNT_W'(DIV4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tick      = 1'b0;
        phase_nxt = phase;
        dir_nxt   = dir_up;
        case (state)
            IDLE: if (bus.select != '0) state_nxt = RUN;
            RUN: begin
                if (bus.select == '0)        state_nxt = IDLE;
                else if (div_cnt == cur_div) tick = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (tick) begin
            if (is_tri) begin
                // Endpoints are not repeated: MAX turns straight to MAX-1; the
                // descent ends at 0, where the period boundary restores dir=up.
                if (dir_up) begin
                    if (phase == MAX) begin
                        phase_nxt = MAX_M1;
                        dir_nxt   = 1'b0;
                    end else begin
                        phase_nxt = phase + 1'b1;
                    end
                end else begin
                    phase_nxt = phase - 1'b1;
                end
            end else begin
                phase_nxt = (phase == MAX) ? '0 : phase + 1'b1;
            end
        end
    end

    assign wrap       = tick && (phase_nxt == '0);
    assign sample_nxt = (cur_mode == 2'b10) ? (phase_nxt[DATA_W-1] ? '0 : MAX) : phase_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            cur_div  <= CNT_W'(DIV0);
            cur_mode <= 2'b00;
            phase    <= '0;
            dir_up   <= 1'b1;
            out_q    <= '0;
            step_q   <= 1'b0;
            ps_q     <= 1'b0;
        end else begin
            step_q <= 1'b0;
            ps_q   <= 1'b0;
            if (state == RUN && state_nxt == RUN) begin
                if (tick) begin
                    div_cnt <= '0;
                    step_q  <= 1'b1;
                    phase   <= phase_nxt;
                    out_q   <= sample_nxt;
                    dir_up  <= dir_nxt;
                    // Pending note/mode are picked up only here, at phase 0.
                    if (wrap) begin
                        ps_q     <= 1'b1;
                        cur_div  <= dec_div;
                        cur_mode <= bus.mode;
                        dir_up   <= 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                div_cnt <= '0;
                phase   <= '0;
                out_q   <= '0;
                dir_up  <= 1'b1;
                if (state == IDLE && state_nxt == RUN) begin
                    cur_div  <= dec_div;
                    cur_mode <= bus.mode;
                    ps_q     <= 1'b1;
                end
            end
        end
    end
endmodule
